// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state encodings for the debounce channels
package debounce_pkg;
    typedef logic [1:0] state_t;
    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_HIGH_JUDGE = 2'd1;
    localparam logic [1:0] S_HIGH       = 2'd2;
    localparam logic [1:0] S_LOW_JUDGE  = 2'd3;
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one channel -- two-flop synchronizer, debounce FSM, saturating counter, edge pulses
// Ports: clk_i/rst_i clock and sync active-high reset; signal_i raw input; en_i channel enable;
//        debounce_time_i stable time N; signal_o debounced level; rise_pulse_o/fall_pulse_o edge pulses
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             signal_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] debounce_time_i,
    output logic             signal_o,
    output logic             rise_pulse_o,
    output logic             fall_pulse_o
);
    logic             s1, s2;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, lim;
    logic             cand, hold, done, sig_nx;
    // cand is the level being judged; hold means s2 still sits at that level
    always_comb begin
        cand     = state == S_HIGH_JUDGE;
        hold     = (cand || state == S_LOW_JUDGE) && s2 == cand;
        lim      = debounce_time_i == '0 ? '0 : debounce_time_i - 1'b1;
        done     = hold && cnt >= lim;
        state_nx = !en_i ? S_IDLE :
                   state == S_IDLE ? (s2 ? S_HIGH_JUDGE : S_IDLE) :
                   state == S_HIGH ? (s2 ? S_HIGH : S_LOW_JUDGE) :
                   done ? (cand ? S_HIGH : S_IDLE) :
                   hold ? state : (cand ? S_IDLE : S_HIGH);
        cnt_nx   = (!en_i || !hold || done) ? '0 : cnt + CNT_W'(~&cnt);
        sig_nx   = state_nx == S_HIGH || state_nx == S_LOW_JUDGE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            state        <= S_IDLE;
            cnt          <= '0;
            signal_o     <= 1'b0;
            rise_pulse_o <= 1'b0;
            fall_pulse_o <= 1'b0;
        end else begin
            s1           <= signal_i;
            s2           <= s1;
            state        <= state_nx;
            cnt          <= cnt_nx;
            signal_o     <= sig_nx;
            rise_pulse_o <= sig_nx & ~signal_o;
            fall_pulse_o <= ~sig_nx & signal_o;
        end
    end
endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: CH_NUM independent debounce channels with a shared debounce time
// Ports: clk_i/rst_i clock and sync active-high reset; signal_i raw inputs; en_i per-channel enable;
//        debounce_time_i stable time N; signal_o debounced levels; rise/fall_pulse_o edge pulses;
//        update_pulse_o registered OR of all edge pulses
module debounce_multi #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CH_NUM-1:0] signal_i,
    input  logic [CH_NUM-1:0] en_i,
    input  logic [CNT_W-1:0]  debounce_time_i,
    output logic [CH_NUM-1:0] signal_o,
    output logic [CH_NUM-1:0] rise_pulse_o,
    output logic [CH_NUM-1:0] fall_pulse_o,
    output logic              update_pulse_o
);
    genvar i;
    for (i = 0; i < CH_NUM; i++) begin : g_ch
        debounce_ch #(.CNT_W(CNT_W)) u_ch (
            .clk_i           (clk_i),
            .rst_i           (rst_i),
            .signal_i        (signal_i[i]),
            .en_i            (en_i[i]),
            .debounce_time_i (debounce_time_i),
            .signal_o        (signal_o[i]),
            .rise_pulse_o    (rise_pulse_o[i]),
            .fall_pulse_o    (fall_pulse_o[i])
        );
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) update_pulse_o <= 1'b0;
        else update_pulse_o <= |(rise_pulse_o | fall_pulse_o);
    end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: run-length reference model plus directed latency/glitch/enable/reset checks
module tb_debounce_multi;
    localparam int CH = 4;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] sig = '0;
    logic [CH-1:0] en  = '0;
    logic [31:0]   n   = '0;
    logic [CH-1:0] so, rp, fp;
    logic          up;
    int            checks = 0, failures = 0;
    bit            chk_on = 1'b0;

    always #5 clk = ~clk;

    debounce_multi #(.CH_NUM(CH), .CNT_W(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .signal_i        (sig),
        .en_i            (en),
        .debounce_time_i (n),
        .signal_o        (so),
        .rise_pulse_o    (rp),
        .fall_pulse_o    (fp),
        .update_pulse_o  (up)
    );

    // Model: the debounced level flips once s2 has differed from it for Neff+1 consecutive edges.
    logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_d = '0, m_rise = '0, m_fall = '0, m_nd;
    logic          m_upd = 1'b0;
    longint        m_run [CH];
    longint        neff;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_d = '0; m_rise = '0; m_fall = '0; m_upd = 1'b0;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
        end else begin
            m_upd = |(m_rise | m_fall);
            neff  = (n == 0) ? 1 : longint'(n);
            for (int c = 0; c < CH; c++) begin
                m_nd[c] = m_d[c];
                if (!en[c]) begin
                    m_nd[c] = 1'b0;
                    m_run[c] = 0;
                end else if (m_s2[c] != m_d[c]) begin
                    m_run[c]++;
                    if (m_run[c] >= neff + 1) begin
                        m_nd[c] = m_s2[c];
                        m_run[c] = 0;
                    end
                end else m_run[c] = 0;
            end
            m_rise = m_nd & ~m_d;
            m_fall = ~m_nd & m_d;
            m_d    = m_nd;
            m_s2   = m_s1;
            m_s1   = sig;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (chk_on) check("model", {so, rp, fp, up}, {m_d, m_rise, m_fall, m_upd});

    task automatic step();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        sig = '0;
        en  = '1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Edges from raw change until signal_o[ch] goes high; -1 if it never does.
    task automatic measure(input int ch, output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (so[ch] && lat < 0) lat = k;
        end
    endtask

    int lat, rise_at, upd_at, rises, cnt;
    int rat [CH];
    int rate;

    initial begin
        n = 32'd10;
        reset_dut();
        chk_on = 1'b1;
        check("reset_outputs", {so, rp, fp, up}, 13'd0);

        // 0->1 on ch0 with N=10
        repeat (5) step();
        sig[0] = 1'b1;
        lat = -1; rise_at = -1; upd_at = -1; rises = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (so[0] && lat < 0) lat = k;
            if (rp[0]) begin rises++; if (rise_at < 0) rise_at = k; end
            if (up && upd_at < 0) upd_at = k;
        end
        check("lat_n10", lat, 13);
        check("rise_at_n10", rise_at, 13);
        check("rise_count_n10", rises, 1);
        check("update_at_n10", upd_at, 14);

        // 5-cycle glitch on ch1 is rejected
        sig[1] = 1'b1;
        repeat (5) step();
        sig[1] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            cnt += int'(so[1]) + int'(rp[1]) + int'(fp[1]);
        end
        check("glitch_ch1", cnt, 0);

        // N=0 and N=1 both take 4 edges
        n = 32'd0;
        reset_dut();
        sig[3] = 1'b1;
        measure(3, lat);
        check("lat_n0", lat, 4);
        n = 32'd1;
        reset_dut();
        sig[3] = 1'b1;
        measure(3, lat);
        check("lat_n1", lat, 4);

        // disable of a stable-high channel
        n = 32'd3;
        reset_dut();
        sig[2] = 1'b1;
        repeat (15) step();
        check("ch2_high", so[2], 1'b1);
        en[2] = 1'b0;
        step();
        check("disable_sig", so[2], 1'b0);
        check("disable_fall", fp[2], 1'b1);
        step();
        check("disable_fall_once", fp[2], 1'b0);
        en[2] = 1'b1;

        // reset mid-judge
        n = 32'd100;
        reset_dut();
        sig[0] = 1'b1;
        repeat (53) step();
        rst = 1'b1;
        sig = '0;
        step();
        check("reset_mid_judge", {so, rp, fp, up}, 13'd0);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            cnt += int'(|rp) + int'(|fp) + int'(up) + int'(|so);
        end
        check("after_reset_quiet", cnt, 0);

        // all channels rise together
        n = 32'd5;
        reset_dut();
        sig = '1;
        cnt = 0;
        for (int c = 0; c < CH; c++) rat[c] = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            for (int c = 0; c < CH; c++) if (rp[c] && rat[c] < 0) rat[c] = k;
            cnt += int'(up);
        end
        for (int c = 0; c < CH; c++) check($sformatf("rise_at_all_ch%0d", c), rat[c], 8);
        check("update_once", cnt, 1);

        // random stimulus against the model
        reset_dut();
        rate = 6;
        for (int c = 0; c < 4000; c++) begin
            if (c % 150 == 0) begin
                n = 32'($urandom_range(0, 8));
                rate = $urandom_range(3, 20);
            end
            for (int ch = 0; ch < CH; ch++)
                if ($urandom_range(rate - 1) == 0) sig[ch] = ~sig[ch];
            if ($urandom_range(60) == 0) en[$urandom_range(CH - 1)] = 1'b0;
            else if ($urandom_range(8) == 0) en = '1;
            rst = ($urandom_range(700) == 0);
            step();
        end
        rst = 1'b0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 4, meaning the number of independent debounce channels (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the width of the debounce-time input and of each channel counter.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port signal_i, input, CH_NUM bits: raw asynchronous channel inputs.
REQ-006 The block SHALL have port en_i, input, CH_NUM bits: per-channel enable.
REQ-007 The block SHALL have port debounce_time_i, input, CNT_W bits: required stable duration N in clk_i cycles, shared by all channels.
REQ-008 The block SHALL have port signal_o, output, CH_NUM bits: debounced level per channel.
REQ-009 The block SHALL have port rise_pulse_o, output, CH_NUM bits: one-cycle pulse on each debounced 0->1 transition.
REQ-010 The block SHALL have port fall_pulse_o, output, CH_NUM bits: one-cycle pulse on each debounced 1->0 transition.
REQ-011 The block SHALL have port update_pulse_o, output, 1 bit: OR of all rise and fall pulses.

Function
REQ-012 The block SHALL pass each signal_i bit through a two-flop synchronizer; s2 denotes the second-stage output.
REQ-013 The block SHALL give each channel an FSM with states S_IDLE (stable low), S_HIGH_JUDGE, S_HIGH (stable high) and S_LOW_JUDGE.
REQ-014 The block SHALL move S_IDLE->S_HIGH_JUDGE when s2=1, and S_HIGH->S_LOW_JUDGE when s2=0, clearing the channel counter on entry.
REQ-015 The block SHALL, in a judge state, increment the counter every cycle that s2 equals the candidate level.
REQ-016 The block SHALL commit the candidate level when s2 equals the candidate and counter >= Neff-1, where Neff = max(N,1); the state, signal_o and the matching rise/fall pulse all update on that same edge.
REQ-017 The block SHALL return to the previous stable state, clear the counter and emit no pulse if s2 leaves the candidate level during judging (bounce).
REQ-018 The block SHALL produce a signal_o change exactly Neff+3 cycles after a raw edge held stable, and no change for glitches shorter than Neff cycles at s2.
REQ-019 The block SHALL saturate the counter at all-ones and never wrap.
REQ-020 The block SHALL compare against the live debounce_time_i each cycle; if N drops mid-judge to <= counter+1, the commit occurs on the next edge.
REQ-021 The block SHALL, when en_i[ch]=0, force that channel to S_IDLE, counter 0 and signal_o[ch]=0; a 1->0 debounced change caused by disable SHALL emit fall_pulse_o[ch].
REQ-022 The block SHALL register update_pulse_o so that it is asserted in the cycle after any rise/fall pulse, for one cycle per such cycle.
REQ-023 The block SHALL keep channels fully independent; simultaneous commits on several channels produce simultaneous pulses and a single update_pulse_o cycle.

Reset
REQ-024 The block SHALL, on rst_i=1 at a clock edge, set all synchronizer flops, counters, signal_o, rise_pulse_o, fall_pulse_o and update_pulse_o to 0 and all FSMs to S_IDLE.
REQ-025 The block SHALL abort any in-progress judge on reset mid-operation, with no pulse emitted during or after the reset cycle.

Structure
REQ-026 The block SHALL take the state encodings (S_IDLE=0, S_HIGH_JUDGE=1, S_HIGH=2, S_LOW_JUDGE=3, 2-bit) from the shared package debounce_pkg.
REQ-027 The block SHALL instantiate one sub-module debounce_ch per channel (synchronizer, FSM, counter, pulses), with debounce_multi containing only the generate loop and the update_pulse_o OR/register.

Verification
REQ-028 The bench SHALL check: N=10, ch0 raw 0->1 held -> signal_o[0]=1 and rise_pulse_o[0] for one cycle exactly 13 cycles later, update_pulse_o one cycle after that.
REQ-029 The bench SHALL check: N=10, ch1 high pulse of 5 cycles -> no change on signal_o[1] and no pulses.
REQ-030 The bench SHALL check: N=0 and N=1 -> both give a latency of 4 cycles.
REQ-031 The bench SHALL check: ch2 stable high, en_i[2] cleared -> signal_o[2]=0 and fall_pulse_o[2] on the next edge.
REQ-032 The bench SHALL check: N=100, rst_i asserted 50 cycles into judging -> all outputs 0, and no pulse after reset releases while the input stays low.
REQ-033 The bench SHALL check: all 4 channels rise on the same cycle -> all rise pulses coincide and update_pulse_o is high for exactly 1 cycle.
